// File: rtl/emir_sirala_if.sv
// Host/core-side signal bundle for the emir_sirala instruction sequencer.
interface emir_sirala_if #(
  parameter int unsigned AW = 4
) ();
  logic          yukle_en;
  logic [AW-1:0] yukle_adres;
  logic [15:0]   yukle_veri;
  logic [AW:0]   uzunluk;
  logic          baslat;
  logic          durdur;
  logic [7:0]    sonuc_i;
  logic [15:0]   emir_o;
  logic          mesgul;
  logic          bitti;
  logic [7:0]    son_sonuc;
  logic [AW-1:0] pc;
  logic [AW:0]   sonuc_sayisi;

  // Host / core model side
  modport master (
    output yukle_en, yukle_adres, yukle_veri, uzunluk, baslat, durdur, sonuc_i,
    input  emir_o, mesgul, bitti, son_sonuc, pc, sonuc_sayisi
  );

  // Sequencer side
  modport slave (
    input  yukle_en, yukle_adres, yukle_veri, uzunluk, baslat, durdur, sonuc_i,
    output emir_o, mesgul, bitti, son_sonuc, pc, sonuc_sayisi
  );
endinterface

// File: rtl/emir_sirala.sv
// Instruction sequencer for the MESS core: holds a small program, issues it
// one word at a time with NOP wait cycles, and captures each result byte.
module emir_sirala #(
  parameter int unsigned DERINLIK = 16,
  parameter int unsigned AW       = 4,
  parameter int unsigned BEKLEME  = 1,
  parameter logic [15:0] NOP_EMIR = 16'h0000
) (
  input logic         clk,
  input logic         rst,
  emir_sirala_if.slave bus
);

  localparam int unsigned LW = AW + 1;
  localparam int unsigned CW = (BEKLEME < 2) ? 1 : $clog2(BEKLEME + 1);

  typedef enum logic [1:0] {BOSTA, GONDER, BEKLE, BITTI} state_t;

  state_t        r_state, w_state_nxt;
  logic [15:0]   r_mem [DERINLIK];
  logic [15:0]   r_emir, w_emir_nxt;
  logic          r_mesgul, w_mesgul_nxt;
  logic          r_bitti, w_bitti_nxt;
  logic [7:0]    r_son, w_son_nxt;
  logic [AW-1:0] r_pc, w_pc_nxt;
  logic [LW-1:0] r_say, w_say_nxt;
  logic [LW-1:0] r_len, w_len_nxt;
  logic [CW-1:0] r_cnt, w_cnt_nxt;
  logic          r_sent, w_sent_nxt;  // GONDER: word already driven this visit
  logic          w_yaz;
  logic          w_last;
  logic [LW-1:0] w_len_clamp;

  assign w_len_clamp = (bus.uzunluk > LW'(DERINLIK)) ? LW'(DERINLIK) : bus.uzunluk;
  assign w_last      = (LW'(r_pc) == (r_len - LW'(1)));

  // Program buffer write port; contents survive reset
  always_ff @(posedge clk) begin
    if (w_yaz) r_mem[bus.yukle_adres] <= bus.yukle_veri;
  end

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= BOSTA;
    else      r_state <= w_state_nxt;
  end

  // Next-state and next-output logic
  always_comb begin
    w_state_nxt  = r_state;
    w_emir_nxt   = NOP_EMIR;
    w_mesgul_nxt = r_mesgul;
    w_bitti_nxt  = 1'b0;
    w_son_nxt    = r_son;
    w_pc_nxt     = r_pc;
    w_say_nxt    = r_say;
    w_len_nxt    = r_len;
    w_cnt_nxt    = r_cnt;
    w_sent_nxt   = r_sent;
    w_yaz        = 1'b0;
    case (r_state)
      BOSTA: begin
        w_yaz = bus.yukle_en;
        if (bus.baslat) begin
          w_pc_nxt  = '0;
          w_say_nxt = '0;
          if (bus.uzunluk == '0) begin
            w_state_nxt = BITTI;
            w_bitti_nxt = 1'b1;
          end else begin
            w_len_nxt    = w_len_clamp;
            w_mesgul_nxt = 1'b1;
            w_sent_nxt   = 1'b0;
            w_state_nxt  = GONDER;
          end
        end
      end
      GONDER: begin
        if (bus.durdur) begin
          w_state_nxt  = BOSTA;
          w_mesgul_nxt = 1'b0;
        end else if (!r_sent) begin
          w_emir_nxt = r_mem[r_pc];
          w_sent_nxt = 1'b1;
        end else begin
          w_sent_nxt  = 1'b0;
          w_cnt_nxt   = CW'(BEKLEME);
          w_state_nxt = BEKLE;
        end
      end
      BEKLE: begin
        if (bus.durdur) begin
          w_state_nxt  = BOSTA;
          w_mesgul_nxt = 1'b0;
        end else if (r_cnt == CW'(1)) begin
          w_cnt_nxt = '0;
          w_son_nxt = bus.sonuc_i;
          w_say_nxt = r_say + LW'(1);
          if (w_last) begin
            w_state_nxt = BITTI;
            w_bitti_nxt = 1'b1;
          end else begin
            w_pc_nxt    = r_pc + AW'(1);
            w_sent_nxt  = 1'b0;
            w_state_nxt = GONDER;
          end
        end else begin
          w_cnt_nxt = r_cnt - CW'(1);
        end
      end
      BITTI: begin
        w_mesgul_nxt = 1'b0;
        w_state_nxt  = BOSTA;
      end
      default: w_state_nxt = BOSTA;
    endcase
  end

  // Registered datapath and outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_emir   <= NOP_EMIR;
      r_mesgul <= 1'b0;
      r_bitti  <= 1'b0;
      r_son    <= '0;
      r_pc     <= '0;
      r_say    <= '0;
      r_len    <= '0;
      r_cnt    <= '0;
      r_sent   <= 1'b0;
    end else begin
      r_emir   <= w_emir_nxt;
      r_mesgul <= w_mesgul_nxt;
      r_bitti  <= w_bitti_nxt;
      r_son    <= w_son_nxt;
      r_pc     <= w_pc_nxt;
      r_say    <= w_say_nxt;
      r_len    <= w_len_nxt;
      r_cnt    <= w_cnt_nxt;
      r_sent   <= w_sent_nxt;
    end
  end

  assign bus.emir_o       = r_emir;
  assign bus.mesgul       = r_mesgul;
  assign bus.bitti        = r_bitti;
  assign bus.son_sonuc    = r_son;
  assign bus.pc           = r_pc;
  assign bus.sonuc_sayisi = r_say;

endmodule
